// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage access unit.
// Contents:
//   - access size encodings carried on req_size
//   - FSM state encoding
//   - lane-mux operating modes
//   - lane offset helper
package mips_mem_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic {
    IDLE     = 1'b0,
    MERGE_WR = 1'b1
  } state_t;

  // byte_lane_mux operating modes
  localparam int LANE_MODE_EXTRACT = 0;
  localparam int LANE_MODE_INSERT  = 1;

  // Half-word lane select, driven by addr[1]
  localparam logic HALF_LANE_LOW  = 1'b0;
  localparam logic HALF_LANE_HIGH = 1'b1;

  // Bit offset of byte lane k (little-endian: byte k lives at bits [8k+7:8k])
  function automatic logic [4:0] lane_shift(input logic [1:0] addr_lo);
    return {addr_lo, 3'b000};
  endfunction

endpackage

// File: rtl/byte_lane_mux.sv
// Little-endian byte/half lane selector.
// MODE = LANE_MODE_EXTRACT:
//   result = the lane of word picked by addr_lo/size, sign- or zero-extended.
// MODE = LANE_MODE_INSERT:
//   result = word with that lane replaced by the low bits of wdata.
// In both modes, a word access passes the whole 32 bits through.
// Ports:
//   word        [31:0]  in   source word (read data from memory)
//   addr_lo     [1:0]   in   low address bits
//   size        [1:0]   in   access size
//   is_unsigned         in   zero-extend on extract when 1
//   wdata       [31:0]  in   right-aligned store data (insert mode)
//   result      [31:0]  out  extracted or merged word
module byte_lane_mux
  import mips_mem_pkg::*;
#(
  parameter int MODE = LANE_MODE_EXTRACT
) (
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] extracted;
  logic [31:0] inserted;

  always_comb begin
    byte_sel = word[lane_shift(addr_lo) +: 8];
    half_sel = (addr_lo[1] == HALF_LANE_HIGH) ? word[31:16] : word[15:0];

    case (size)
      SIZE_BYTE: extracted = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SIZE_HALF: extracted = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default:   extracted = word;
    endcase

    inserted = word;
    case (size)
      SIZE_BYTE: inserted[lane_shift(addr_lo) +: 8] = wdata[7:0];
      SIZE_HALF: begin
        if (addr_lo[1] == HALF_LANE_HIGH) inserted[31:16] = wdata[15:0];
        else                              inserted[15:0]  = wdata[15:0];
      end
      default:   inserted = wdata;
    endcase

    result = (MODE == LANE_MODE_INSERT) ? inserted : extracted;
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-addressed data memory.
// Behaviour:
//   - Word stores and all loads complete in one cycle.
//   - Byte/half stores do a read-modify-write: read and merge in IDLE
//     (stall high), then write the merged word in MERGE_WR.
//   - Misaligned or illegal-size requests are suppressed and flagged.
// Ports:
//   clk, reset (async, active-high)
//   req_valid, req_write, req_size[1:0], req_unsigned,
//   req_addr[31:0], req_wdata[31:0]          pipeline request
//   stall                                     hold request stable
//   load_data[31:0], load_valid, misaligned   registered results
//   mem_addr[31:0], mem_write_data[31:0],
//   mem_memwrite, mem_memread                 memory side
//   mem_read_data[31:0]                       combinational read word
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int CHECK_ALIGN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_read_data
);

  state_t      state, state_next;
  logic [31:0] merge_reg;
  logic [31:0] extract_word;
  logic [31:0] insert_word;
  logic        bad_align;
  logic        fault;
  logic        take_load;
  logic        take_sub_store;
  logic        flag_fault;

  byte_lane_mux #(.MODE(LANE_MODE_EXTRACT)) u_extract (
    .word        (mem_read_data),
    .addr_lo     (req_addr[1:0]),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .result      (extract_word)
  );

  byte_lane_mux #(.MODE(LANE_MODE_INSERT)) u_insert (
    .word        (mem_read_data),
    .addr_lo     (req_addr[1:0]),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .result      (insert_word)
  );

  // With alignment checking off, the lane mux simply ignores the low bits
  // that do not matter for the size, so only the illegal size can fault.
  always_comb begin
    bad_align = (CHECK_ALIGN != 0) &&
                (((req_size == SIZE_HALF) && req_addr[0]) ||
                 ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00)));
    fault = (req_size == SIZE_ILLEGAL) || bad_align;
  end

  // Every output is forced low while reset is high; this also aborts a
  // pending merge write immediately.
  always_comb begin
    state_next     = state;
    stall          = 1'b0;
    mem_memread    = 1'b0;
    mem_memwrite   = 1'b0;
    mem_write_data = 32'd0;
    mem_addr       = 32'd0;
    take_load      = 1'b0;
    take_sub_store = 1'b0;
    flag_fault     = 1'b0;
    if (!reset) begin
      mem_addr = {2'b00, req_addr[31:2]};
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (fault) begin
              flag_fault = 1'b1;
            end else if (req_write) begin
              if (req_size == SIZE_WORD) begin
                mem_memwrite   = 1'b1;
                mem_write_data = req_wdata;
              end else begin
                mem_memread    = 1'b1;
                stall          = 1'b1;
                take_sub_store = 1'b1;
                state_next     = MERGE_WR;
              end
            end else begin
              mem_memread = 1'b1;
              take_load   = 1'b1;
            end
          end
        end
        MERGE_WR: begin
          // Request is held stable by the stall, so mem_addr is still valid.
          mem_memwrite   = 1'b1;
          mem_write_data = merge_reg;
          state_next     = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      merge_reg  <= 32'd0;
      load_data  <= 32'd0;
      load_valid <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_next;
      load_valid <= take_load;
      misaligned <= flag_fault;
      if (take_load)      load_data <= extract_word;
      if (take_sub_store) merge_reg <= insert_word;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_read_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:63] = '{default: 32'd0};

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_addr[5:0]];
  always @(posedge clk) if (mem_memwrite) mem[mem_addr[5:0]] <= mem_write_data;

  mem_access_unit #(.CHECK_ALIGN(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .stall          (stall),
    .load_data      (load_data),
    .load_valid     (load_valid),
    .misaligned     (misaligned),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_read_data  (mem_read_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] d);
    req_valid = v; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'd54);
    #1;
    check("rst_stall",     {31'd0, stall},        32'd0);
    check("rst_memwrite",  {31'd0, mem_memwrite}, 32'd0);
    check("rst_memread",   {31'd0, mem_memread},  32'd0);
    check("rst_mem_addr",  mem_addr,              32'd0);
    check("rst_load_val",  {31'd0, load_valid},   32'd0);
    check("rst_load_data", load_data,             32'd0);
    check("rst_misalign",  {31'd0, misaligned},   32'd0);

    // word store 54 at 0x8
    @(negedge clk); reset = 1'b0; #1;
    check("ws_memwrite", {31'd0, mem_memwrite}, 32'd1);
    check("ws_memread",  {31'd0, mem_memread},  32'd0);
    check("ws_addr",     mem_addr,              32'd2);
    check("ws_data",     mem_write_data,        32'd54);
    check("ws_stall",    {31'd0, stall},        32'd0);
    $display("txn word store addr=0x8 data=54");

    // word load 0x8
    @(negedge clk);
    check("ws_mem2", mem[2], 32'd54);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'd0); #1;
    check("wl_memread", {31'd0, mem_memread}, 32'd1);
    check("wl_stall",   {31'd0, stall},       32'd0);
    @(negedge clk);
    check("wl_valid", {31'd0, load_valid}, 32'd1);
    check("wl_data",  load_data,           32'd54);
    $display("txn word load addr=0x8 data=%h", load_data);
    idle();
    @(negedge clk);
    check("wl_pulse", {31'd0, load_valid}, 32'd0);
    check("wl_hold",  load_data,           32'd54);

    // preload words through the unit
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'hC, 32'h11223344);
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h24, 32'h00000010);
    @(negedge clk);
    check("pre_mem3", mem[3], 32'h11223344);
    check("pre_mem9", mem[9], 32'h00000010);
    $display("txn preload mem3=%h mem9=%h", mem[3], mem[9]);

    // byte store 0xAA at 0xD
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'hD, 32'h000000AA); #1;
    check("bs_stall",   {31'd0, stall},        32'd1);
    check("bs_memread", {31'd0, mem_memread},  32'd1);
    check("bs_nowrite", {31'd0, mem_memwrite}, 32'd0);
    @(negedge clk); #1;
    check("bs_mw_write", {31'd0, mem_memwrite}, 32'd1);
    check("bs_mw_read",  {31'd0, mem_memread},  32'd0);
    check("bs_mw_stall", {31'd0, stall},        32'd0);
    check("bs_mw_addr",  mem_addr,              32'd3);
    check("bs_mw_data",  mem_write_data,        32'h1122AA44);
    $display("txn byte store addr=0xD data=AA merged=%h", mem_write_data);

    // back-to-back byte load, signed then unsigned
    @(negedge clk);
    check("bs_mem3", mem[3], 32'h1122AA44);
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'hD, 32'd0); #1;
    check("bl_memread", {31'd0, mem_memread}, 32'd1);
    check("bl_stall",   {31'd0, stall},       32'd0);
    @(negedge clk);
    check("bl_s_valid", {31'd0, load_valid}, 32'd1);
    check("bl_s_data",  load_data,           32'hFFFFFFAA);
    $display("txn byte load signed addr=0xD data=%h", load_data);
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'hD, 32'd0);
    @(negedge clk);
    check("bl_u_data", load_data, 32'h000000AA);
    $display("txn byte load unsigned addr=0xD data=%h", load_data);

    // half store 0xBEEF at 0x26
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h26, 32'h0000BEEF); #1;
    check("hs_stall", {31'd0, stall}, 32'd1);
    @(negedge clk); #1;
    check("hs_mw_data", mem_write_data, 32'hBEEF0010);
    check("hs_mw_addr", mem_addr,       32'd9);
    @(negedge clk);
    check("hs_mem9", mem[9], 32'hBEEF0010);
    $display("txn half store addr=0x26 data=BEEF merged=%h", mem[9]);
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h26, 32'd0);
    @(negedge clk);
    check("hl_data", load_data, 32'hFFFFBEEF);
    $display("txn half load signed addr=0x26 data=%h", load_data);

    // faults: word load 0x9, half store 0x3, size 11
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h9, 32'd0); #1;
    check("f1_memread",  {31'd0, mem_memread},  32'd0);
    check("f1_memwrite", {31'd0, mem_memwrite}, 32'd0);
    check("f1_stall",    {31'd0, stall},        32'd0);
    @(negedge clk);
    check("f1_misalign", {31'd0, misaligned}, 32'd1);
    check("f1_novalid",  {31'd0, load_valid}, 32'd0);
    $display("txn word load addr=0x9 misaligned=%0d", misaligned);
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h3, 32'h00001234); #1;
    check("f2_memread",  {31'd0, mem_memread},  32'd0);
    check("f2_memwrite", {31'd0, mem_memwrite}, 32'd0);
    check("f2_stall",    {31'd0, stall},        32'd0);
    @(negedge clk);
    check("f2_misalign", {31'd0, misaligned}, 32'd1);
    $display("txn half store addr=0x3 misaligned=%0d", misaligned);
    drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h8, 32'd0); #1;
    check("f3_memread",  {31'd0, mem_memread},  32'd0);
    check("f3_memwrite", {31'd0, mem_memwrite}, 32'd0);
    @(negedge clk);
    check("f3_misalign", {31'd0, misaligned}, 32'd1);
    check("f3_novalid",  {31'd0, load_valid}, 32'd0);
    $display("txn size11 load addr=0x8 misaligned=%0d", misaligned);
    idle();
    @(negedge clk);
    check("f_pulse", {31'd0, misaligned}, 32'd0);
    check("f_mem0",  mem[0], 32'd0);
    check("f_mem2",  mem[2], 32'd54);

    // reset during MERGE_WR aborts the write
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h8, 32'h00000077);
    @(negedge clk); #1;
    check("ra_mw_write", {31'd0, mem_memwrite}, 32'd1);
    reset = 1'b1; #1;
    check("ra_write_drop", {31'd0, mem_memwrite}, 32'd0);
    check("ra_stall",      {31'd0, stall},        32'd0);
    check("ra_addr",       mem_addr,              32'd0);
    check("ra_wdata",      mem_write_data,        32'd0);
    check("ra_load_data",  load_data,             32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(); #1;
    check("ra_mem2",  mem[2], 32'd54);
    check("ra_state", {31'd0, mem_memwrite}, 32'd0);
    $display("txn reset in merge mem2=%h", mem[2]);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'd0);
    @(negedge clk);
    check("ra_ld_valid", {31'd0, load_valid}, 32'd1);
    check("ra_ld_data",  load_data,           32'd54);
    $display("txn word load after reset addr=0x8 data=%h", load_data);
    idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
